// File: rtl/pcie_tlp_tx_arbiter_pkg.sv
// Shared types and constants for the PCIe TLP transmit arbiter.
// Latency: none; this file holds only types, constants and helpers.
// Backpressure: not applicable.
package pcie_tlp_tx_arbiter_pkg;

    localparam int PIPE_DATA_WIDTH = 256;
    localparam int NUM_TX_SRC      = 3;
    localparam int SRC_IDX_W       = 2;

    // Class encoding matches the source bit index: P, NP, Cpl.
    typedef enum logic [1:0] {
        FC_P   = 2'd0,
        FC_NP  = 2'd1,
        FC_CPL = 2'd2
    } fc_class_e;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } tx_arb_state_e;

    function automatic logic [SRC_IDX_W-1:0] onehot_to_idx(input logic [NUM_TX_SRC-1:0] oh);
        logic [SRC_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_TX_SRC; i++) begin
            if (oh[i]) begin
                idx = SRC_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pcie_rr_arbiter.sv
// Round-robin one-hot picker; search starts one past the previous winner.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module pcie_rr_arbiter #(
    parameter int N = 3
) (
    input  logic [N-1:0]         eligible,
    input  logic [$clog2(N)-1:0] last_grant,
    output logic [N-1:0]         pick,
    output logic                 any
);

    localparam int IW = $clog2(N);

    logic found;

    function automatic logic [IW-1:0] wrap(input int v);
        return IW'(v % N);
    endfunction

    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!found && eligible[wrap(int'(last_grant) + k)]) begin
                pick[wrap(int'(last_grant) + k)] = 1'b1;
                found = 1'b1;
            end
        end
    end

    assign any = |eligible;

endmodule

// File: rtl/pcie_tlp_tx_arbiter.sv
// Shares the TLP transmit path among P/NP/Cpl sources, whole packets, gated by header credits.
// Latency: one IDLE cycle to arbitrate, then a combinational pass-through of the granted source.
// Backpressure: tx_ready_i is returned only to the granted source; others see ready low.
module pcie_tlp_tx_arbiter
    import pcie_tlp_tx_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = PIPE_DATA_WIDTH,
    parameter int CRED_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_TX_SRC-1:0]            src_valid_i,
    input  logic [NUM_TX_SRC*DATA_WIDTH-1:0] src_data_i,
    input  logic [NUM_TX_SRC-1:0]            src_last_i,
    output logic [NUM_TX_SRC-1:0]            src_ready_o,
    output logic                             tx_valid_o,
    output logic [DATA_WIDTH-1:0]            tx_data_o,
    output logic                             tx_last_o,
    input  logic                             tx_ready_i,
    input  logic                             fc_init_valid_i,
    input  logic                             fc_upd_valid_i,
    input  logic [1:0]                       fc_class_i,
    input  logic [CRED_WIDTH-1:0]            fc_value_i,
    output logic [NUM_TX_SRC*CRED_WIDTH-1:0] hdr_cred_o
);

    tx_arb_state_e         state;
    logic [SRC_IDX_W-1:0]  grant;
    logic [SRC_IDX_W-1:0]  last_grant;
    logic [DATA_WIDTH-1:0] src_data [NUM_TX_SRC];
    logic [CRED_WIDTH-1:0] hdr_cred [NUM_TX_SRC];
    logic [NUM_TX_SRC-1:0] eligible;
    logic [NUM_TX_SRC-1:0] pick;
    logic [NUM_TX_SRC-1:0] consume;
    logic                  pick_any;
    logic                  pkt_done;

    for (genvar i = 0; i < NUM_TX_SRC; i++) begin : g_src
        assign src_data[i] = src_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        assign eligible[i] = src_valid_i[i] & (hdr_cred[i] != '0);
        assign hdr_cred_o[i*CRED_WIDTH +: CRED_WIDTH] = hdr_cred[i];
    end

    pcie_rr_arbiter #(
        .N (NUM_TX_SRC)
    ) u_rr (
        .eligible   (eligible),
        .last_grant (last_grant),
        .pick       (pick),
        .any        (pick_any)
    );

    // A header credit is spent at the moment of grant, never per beat.
    assign consume = (state == ARB_IDLE) ? pick : '0;

    always_comb begin
        tx_valid_o  = 1'b0;
        tx_data_o   = '0;
        tx_last_o   = 1'b0;
        src_ready_o = '0;
        if (state == ARB_BUSY) begin
            tx_valid_o         = src_valid_i[grant];
            tx_data_o          = src_data[grant];
            tx_last_o          = src_last_i[grant];
            src_ready_o[grant] = tx_ready_i;
        end
    end

    assign pkt_done = (state == ARB_BUSY) & tx_valid_o & tx_ready_i & tx_last_o;

    // Grant is held through bubbles until the last beat is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            last_grant <= SRC_IDX_W'(NUM_TX_SRC - 1);
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grant <= onehot_to_idx(pick);
                        state <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (pkt_done) begin
                        last_grant <= grant;
                        state      <= ARB_IDLE;
                    end
                end
            endcase
        end
    end

    // Init overrides update; the grant-time consume applies on top of either.
    function automatic logic [CRED_WIDTH-1:0] cred_next(
        input logic [CRED_WIDTH-1:0] cur,
        input logic                  ld,
        input logic                  add,
        input logic                  take,
        input logic [CRED_WIDTH-1:0] val
    );
        logic [CRED_WIDTH:0] sum;
        if (ld) begin
            sum = {1'b0, val};
        end else if (add) begin
            sum = {1'b0, cur} + {1'b0, val};
        end else begin
            sum = {1'b0, cur};
        end
        if (take && (sum != '0)) begin
            sum = sum - (CRED_WIDTH+1)'(1);
        end
        return sum[CRED_WIDTH] ? '1 : sum[CRED_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_TX_SRC; c++) begin
                hdr_cred[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_TX_SRC; c++) begin
                hdr_cred[c] <= cred_next(hdr_cred[c],
                                         fc_init_valid_i && (fc_class_i == SRC_IDX_W'(c)),
                                         fc_upd_valid_i  && (fc_class_i == SRC_IDX_W'(c)),
                                         consume[c],
                                         fc_value_i);
            end
        end
    end

endmodule

// File: tb/tb_pcie_tlp_tx_arbiter.sv
// Bench for pcie_tlp_tx_arbiter: vector table, directed corner sequences, randomized run vs reference model.
module tb_pcie_tlp_tx_arbiter;

    localparam int DW = 256;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [2:0]      src_valid;
    logic [DW-1:0]   sd [3];
    logic [3*DW-1:0] src_data;
    logic [2:0]      src_last;
    logic [2:0]      src_ready;
    logic            tx_valid;
    logic [DW-1:0]   tx_data;
    logic            tx_last;
    logic            tx_ready;
    logic            fc_init_valid;
    logic            fc_upd_valid;
    logic [1:0]      fc_class;
    logic [CW-1:0]   fc_value;
    logic [3*CW-1:0] hdr_cred;

    assign src_data = {sd[2], sd[1], sd[0]};

    pcie_tlp_tx_arbiter #(.DATA_WIDTH(DW), .CRED_WIDTH(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .src_valid_i     (src_valid),
        .src_data_i      (src_data),
        .src_last_i      (src_last),
        .src_ready_o     (src_ready),
        .tx_valid_o      (tx_valid),
        .tx_data_o       (tx_data),
        .tx_last_o       (tx_last),
        .tx_ready_i      (tx_ready),
        .fc_init_valid_i (fc_init_valid),
        .fc_upd_valid_i  (fc_upd_valid),
        .fc_class_i      (fc_class),
        .fc_value_i      (fc_value),
        .hdr_cred_o      (hdr_cred)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: which source owns the link, who won last, credits as plain integers.
    bit m_busy;
    int m_grant;
    int m_last;
    int m_cred [3];
    bit m_fire [3];

    logic            obs_valid;
    logic            obs_last;
    logic [DW-1:0]   obs_data;
    logic [2:0]      obs_ready;
    logic [3*CW-1:0] obs_cred;

    typedef struct {
        logic [2:0]  valid;
        logic [2:0]  last;
        logic [2:0]  exp_ready;
        logic        exp_valid;
        logic        exp_last;
        int          exp_src;
        logic [23:0] exp_cred;
    } vec_t;

    vec_t tbl [10];

    int cnt, b, n, pk, lastacc, early;
    int rlen [3];
    int rbeat [3];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int src, input int beat);
        return {8{32'(32'hB000_0000 + src * 256 + beat)}};
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_grant = 0;
        m_last  = 2;
        for (int c = 0; c < 3; c++) begin
            m_cred[c] = 0;
            m_fire[c] = 1'b0;
        end
    endtask

    task automatic model_check();
        logic          ev, el;
        logic [DW-1:0] ed;
        logic [2:0]    er;
        logic [23:0]   ec;
        ev = 1'b0; el = 1'b0; ed = '0; er = '0;
        if (m_busy) begin
            ev = src_valid[m_grant];
            el = src_last[m_grant];
            ed = sd[m_grant];
            er = tx_ready ? 3'(1 << m_grant) : 3'b000;
        end
        for (int c = 0; c < 3; c++) ec[c*8 +: 8] = 8'(m_cred[c]);
        check("tx_valid", obs_valid, ev);
        check("tx_data", obs_data, ed);
        check("tx_last", obs_last, el);
        check("src_ready", obs_ready, er);
        check("hdr_cred", obs_cred, ec);
    endtask

    task automatic model_update();
        int pick, v, s;
        if (!rst_n) begin
            model_reset();
            return;
        end
        pick = -1;
        for (int c = 0; c < 3; c++) m_fire[c] = 1'b0;
        if (!m_busy) begin
            for (int k = 1; k <= 3; k++) begin
                s = (m_last + k) % 3;
                if (pick < 0 && src_valid[s] && m_cred[s] > 0) pick = s;
            end
            if (pick >= 0) begin
                m_busy  = 1'b1;
                m_grant = pick;
            end
        end else if (src_valid[m_grant] && tx_ready) begin
            m_fire[m_grant] = 1'b1;
            if (src_last[m_grant]) begin
                m_busy = 1'b0;
                m_last = m_grant;
            end
        end
        for (int c = 0; c < 3; c++) begin
            v = m_cred[c];
            if (fc_init_valid && int'(fc_class) == c) v = int'(fc_value);
            else if (fc_upd_valid && int'(fc_class) == c) v = v + int'(fc_value);
            if (pick == c) v = v - 1;
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            m_cred[c] = v;
        end
    endtask

    // One clock: sample and compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        @(negedge clk);
        obs_valid = tx_valid;
        obs_last  = tx_last;
        obs_data  = tx_data;
        obs_ready = src_ready;
        obs_cred  = hdr_cred;
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        src_valid = '0;
        src_last = '0;
        tx_ready = 1'b1;
        fc_init_valid = 1'b0;
        fc_upd_valid = 1'b0;
        fc_class = '0;
        fc_value = '0;
        for (int i = 0; i < 3; i++) sd[i] = pat(i, 0);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic fc_init(input int cls, input int val);
        fc_init_valid = 1'b1;
        fc_class = 2'(cls);
        fc_value = 8'(val);
        cycle();
        fc_init_valid = 1'b0;
    endtask

    task automatic send_pkt(input int src, input int len);
        int bb, nn;
        bb = 0;
        nn = 0;
        src_valid[src] = 1'b1;
        while (bb < len && nn < 40) begin
            sd[src] = pat(src, bb);
            src_last[src] = (bb == len - 1);
            cycle();
            nn++;
            if (m_fire[src]) begin
                check("pkt_beat_data", obs_data, pat(src, bb));
                check("pkt_beat_last", obs_last, bb == len - 1);
                bb++;
            end
        end
        check("pkt_complete", bb, len);
        src_valid[src] = 1'b0;
        src_last[src] = 1'b0;
    endtask

    initial begin
        tbl[0] = '{3'b111, 3'b000, 3'b000, 1'b0, 1'b0, 3, {8'd4, 8'd4, 8'd4}};
        tbl[1] = '{3'b111, 3'b000, 3'b001, 1'b1, 1'b0, 0, {8'd4, 8'd4, 8'd3}};
        tbl[2] = '{3'b111, 3'b001, 3'b001, 1'b1, 1'b1, 0, {8'd4, 8'd4, 8'd3}};
        tbl[3] = '{3'b110, 3'b000, 3'b000, 1'b0, 1'b0, 3, {8'd4, 8'd4, 8'd3}};
        tbl[4] = '{3'b110, 3'b000, 3'b010, 1'b1, 1'b0, 1, {8'd4, 8'd3, 8'd3}};
        tbl[5] = '{3'b110, 3'b010, 3'b010, 1'b1, 1'b1, 1, {8'd4, 8'd3, 8'd3}};
        tbl[6] = '{3'b100, 3'b000, 3'b000, 1'b0, 1'b0, 3, {8'd4, 8'd3, 8'd3}};
        tbl[7] = '{3'b100, 3'b000, 3'b100, 1'b1, 1'b0, 2, {8'd3, 8'd3, 8'd3}};
        tbl[8] = '{3'b100, 3'b100, 3'b100, 1'b1, 1'b1, 2, {8'd3, 8'd3, 8'd3}};
        tbl[9] = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3, {8'd3, 8'd3, 8'd3}};

        // Reset values with sources requesting during reset.
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        src_valid = 3'b111;
        src_last = 3'b111;
        cycle();
        check("rst_tx_valid", obs_valid, 1'b0);
        check("rst_tx_last", obs_last, 1'b0);
        check("rst_tx_data", obs_data, '0);
        check("rst_src_ready", obs_ready, 3'b000);
        check("rst_hdr_cred", obs_cred, '0);
        cycle();
        rst_n = 1'b1;
        cycle();
        check("nocred_no_grant", obs_valid, 1'b0);

        // Three sources, 2-beat packets each, 4 credits per class.
        do_reset();
        fc_init(0, 4);
        fc_init(1, 4);
        fc_init(2, 4);
        for (int i = 0; i < 3; i++) sd[i] = {8{32'(32'hC0DE_0000 + i)}};
        for (int v = 0; v < 10; v++) begin
            src_valid = tbl[v].valid;
            src_last = tbl[v].last;
            cycle();
            check("tbl_valid", obs_valid, tbl[v].exp_valid);
            check("tbl_last", obs_last, tbl[v].exp_last);
            check("tbl_ready", obs_ready, tbl[v].exp_ready);
            check("tbl_data", obs_data, (tbl[v].exp_src == 3) ? '0 : sd[tbl[v].exp_src]);
            check("tbl_cred", obs_cred, tbl[v].exp_cred);
        end

        // Cpl blocked with zero credit, released by an update.
        do_reset();
        fc_init(0, 4);
        src_valid = 3'b100;
        src_last = 3'b100;
        cnt = 0;
        repeat (20) begin
            cycle();
            if (obs_valid) cnt++;
        end
        check("cpl_blocked_cnt", cnt, 0);
        fc_upd_valid = 1'b1;
        fc_class = 2'd2;
        fc_value = 8'd1;
        cycle();
        fc_upd_valid = 1'b0;
        cycle();
        check("cpl_start_plus1", obs_valid, 1'b0);
        cycle();
        check("cpl_start_plus2", obs_valid, 1'b1);
        check("cpl_cred_zero", obs_cred[23:16], 8'd0);
        src_valid = '0;
        src_last = '0;
        cycle();

        // 4-beat P packet with tx_ready toggling.
        do_reset();
        fc_init(0, 4);
        src_valid = 3'b001;
        b = 0; n = 0; lastacc = 0; early = 0;
        while (b < 4 && n < 30) begin
            sd[0] = pat(0, b);
            src_last[0] = (b == 3);
            cycle();
            n++;
            if (obs_valid) check("p_ready_mirror", obs_ready, {2'b00, tx_ready});
            if (obs_valid && obs_last && b < 3) early++;
            if (m_fire[0]) begin
                if (obs_last) lastacc++;
                b++;
            end
            tx_ready = ~tx_ready;
        end
        check("p4_beats", b, 4);
        check("p4_last_once", lastacc, 1);
        check("p4_early_last", early, 0);
        tx_ready = 1'b1;
        src_valid = '0;
        src_last = '0;
        cycle();

        // Saturation, init+consume, init beats update.
        do_reset();
        fc_init(0, 255);
        src_valid = 3'b001;
        src_last = 3'b001;
        fc_upd_valid = 1'b1;
        fc_class = 2'd0;
        fc_value = 8'd10;
        cycle();
        fc_upd_valid = 1'b0;
        cycle();
        check("p_sat", obs_cred[7:0], 8'd255);
        src_valid = '0;
        cycle();
        src_valid = 3'b001;
        fc_init(0, 5);
        cycle();
        check("p_init_consume", obs_cred[7:0], 8'd4);
        src_valid = '0;
        fc_init_valid = 1'b1;
        fc_upd_valid = 1'b1;
        fc_class = 2'd1;
        fc_value = 8'd7;
        cycle();
        fc_init_valid = 1'b0;
        fc_upd_valid = 1'b0;
        cycle();
        check("np_init_wins", obs_cred[15:8], 8'd7);
        src_last = '0;

        // Reset during beat 2 of a 3-beat NP packet, then restart.
        do_reset();
        fc_init(1, 4);
        src_valid = 3'b010;
        b = 0; n = 0;
        while (b < 1 && n < 10) begin
            sd[1] = pat(1, b);
            src_last[1] = 1'b0;
            cycle();
            n++;
            if (m_fire[1]) b++;
        end
        check("np_beat1_accepted", b, 1);
        sd[1] = pat(1, 1);
        rst_n = 1'b0;
        model_reset();
        cycle();
        check("rst_mid_valid", obs_valid, 1'b0);
        check("rst_mid_ready", obs_ready, 3'b000);
        check("rst_mid_cred", obs_cred, '0);
        rst_n = 1'b1;
        cycle();
        fc_init(1, 2);
        send_pkt(1, 3);
        cycle();
        check("np_cred_after_restart", obs_cred[15:8], 8'd1);

        // Back-to-back single-beat NP packets.
        do_reset();
        fc_init(1, 30);
        src_valid = 3'b010;
        src_last = 3'b010;
        sd[1] = pat(1, 9);
        pk = 0;
        repeat (20) begin
            cycle();
            if (m_fire[1]) pk++;
        end
        check("np_b2b_cnt", pk, 10);
        src_valid = '0;
        src_last = '0;
        cycle();
        check("np_b2b_cred", obs_cred[15:8], 8'd20);

        // Randomized traffic, credits and occasional mid-packet reset.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            rbeat[i] = 0;
            rlen[i] = $urandom_range(1, 4);
            sd[i] = {8{32'($urandom)}};
        end
        for (int t = 0; t < 4000; t++) begin
            for (int i = 0; i < 3; i++) begin
                if (m_fire[i]) begin
                    rbeat[i]++;
                    if (rbeat[i] == rlen[i]) begin
                        rbeat[i] = 0;
                        rlen[i] = $urandom_range(1, 4);
                    end
                    sd[i] = {8{32'($urandom)}};
                end
                src_valid[i] = ($urandom_range(0, 9) < 8);
                src_last[i] = (rbeat[i] == rlen[i] - 1);
            end
            tx_ready = ($urandom_range(0, 3) != 0);
            fc_init_valid = ($urandom_range(0, 49) == 0);
            fc_upd_valid = ($urandom_range(0, 3) == 0);
            fc_class = 2'($urandom_range(0, 3));
            fc_value = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                model_reset();
                cycle();
                rst_n = 1'b1;
                for (int i = 0; i < 3; i++) rbeat[i] = 0;
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
